// File: rtl/uart_prog_loader.sv
// Framed program loader: SYNC, LEN, LEN data bytes, CHK (8-bit sum).
// Writes the payload into instruction RAM and releases the CPU on a good checksum.
module uart_prog_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t            r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_count;
  logic [7:0]        r_sum;
  logic [TW-1:0]     r_tcnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_reset;
  logic              r_load_done;
  logic              r_load_error;

  logic [7:0]        w_cnt_next;
  logic [7:0]        w_sum_next;
  logic [TW-1:0]     w_tnext;

  assign w_cnt_next = r_count + 8'd1;
  assign w_sum_next = r_sum + rx_data;
  assign w_tnext    = r_tcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_count      <= '0;
      r_sum        <= '0;
      r_tcnt       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      if (rx_valid) begin
        // A byte always restarts the inter-byte timer, even at the limit
        r_tcnt <= '0;
        case (r_state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_state      <= LEN;
              r_cpu_reset  <= 1'b1;
              r_load_error <= 1'b0;
              r_mem_addr   <= '0;
              r_sum        <= '0;
              r_count      <= '0;
            end
          end
          LEN: begin
            if (rx_data == 8'd0) begin
              r_state      <= IDLE;
              r_load_error <= 1'b1;
            end else begin
              r_len   <= rx_data;
              r_state <= DATA;
            end
          end
          DATA: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(r_count);
            r_mem_wdata <= rx_data;
            r_sum       <= w_sum_next;
            r_count     <= w_cnt_next;
            if (w_cnt_next == r_len) r_state <= CHK;
          end
          CHK: begin
            r_state <= IDLE;
            if (rx_data == r_sum) begin
              r_cpu_reset <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_load_error <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (w_tnext == TW'(TIMEOUT)) begin
          r_state      <= IDLE;
          r_load_error <= 1'b1;
          r_tcnt       <= '0;
        end else begin
          r_tcnt <= w_tnext;
        end
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = (r_state != IDLE);
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: good/bad frames, noise,
// timeout boundary, reload with embedded sync, reset mid-frame.
module tb_uart_prog_loader;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       load_done;
  logic       load_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] wa [0:63];
  logic [7:0] wd [0:63];
  int         wn = 0;
  int         ldn = 0;

  uart_prog_loader #(
    .ADDR_W   (8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (mem_we === 1'b1 && wn < 64) begin
      wa[wn] = mem_addr;
      wd[wn] = mem_wdata;
      wn++;
    end
    if (load_done === 1'b1) ldn++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with outputs settled
  task automatic pulse(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap();
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we",    mem_we,     0);
    chk("rst_addr",  mem_addr,   0);
    chk("rst_wdata", mem_wdata,  0);
    chk("rst_cpu",   cpu_reset,  1);
    chk("rst_busy",  busy,       0);
    chk("rst_done",  load_done,  0);
    chk("rst_err",   load_error, 0);
    rst = 1'b0;
    gap();

    // Good frame, back-to-back bytes
    wn = 0; ldn = 0;
    pulse(8'hA5);
    chk("g_busy", busy, 1);
    chk("g_cpu0", cpu_reset, 1);
    pulse(8'h03);
    chk("g_len_we", mem_we, 0);
    pulse(8'h11);
    chk("g_we0", mem_we, 1);
    chk("g_a0", mem_addr, 0);
    chk("g_d0", mem_wdata, 8'h11);
    pulse(8'h22);
    chk("g_a1", mem_addr, 1);
    chk("g_d1", mem_wdata, 8'h22);
    pulse(8'h33);
    chk("g_we2", mem_we, 1);
    chk("g_a2", mem_addr, 2);
    chk("g_d2", mem_wdata, 8'h33);
    pulse(8'h66);
    chk("g_done", load_done, 1);
    chk("g_cpu", cpu_reset, 0);
    chk("g_err", load_error, 0);
    chk("g_busy_end", busy, 0);
    chk("g_we_end", mem_we, 0);
    chk("g_a_hold", mem_addr, 2);
    chk("g_d_hold", mem_wdata, 8'h33);
    gap();
    chk("g_done_1cyc", load_done, 0);
    chk("g_wn", wn, 3);
    chk("g_wd1", wd[1], 8'h22);
    chk("g_ldn", ldn, 1);

    // Bad checksum, one idle cycle between bytes
    wn = 0; ldn = 0;
    pulse(8'hA5);
    chk("b_cpu", cpu_reset, 1);
    gap(); pulse(8'h02);
    gap(); pulse(8'h10);
    gap(); pulse(8'h20);
    gap(); pulse(8'h31);
    chk("b_err", load_error, 1);
    chk("b_cpu_end", cpu_reset, 1);
    chk("b_busy", busy, 0);
    gap();
    chk("b_ldn", ldn, 0);
    chk("b_wn", wn, 2);
    chk("b_wa1", wa[1], 1);
    chk("b_wd1", wd[1], 8'h20);

    // Noise in IDLE, then zero length
    wn = 0;
    pulse(8'h00);
    chk("n_busy0", busy, 0);
    pulse(8'hFF);
    chk("n_busyff", busy, 0);
    chk("n_err_sticky", load_error, 1);
    pulse(8'hA5);
    chk("n_busy_sync", busy, 1);
    chk("n_err_clr", load_error, 0);
    pulse(8'h00);
    chk("z_err", load_error, 1);
    chk("z_busy", busy, 0);
    gap();
    chk("z_wn", wn, 0);

    // Timeout after one data byte
    wn = 0;
    pulse(8'hA5);
    pulse(8'h02);
    pulse(8'h7E);
    repeat (TO - 1) @(negedge clk);
    chk("t_busy_pre", busy, 1);
    chk("t_err_pre", load_error, 0);
    @(negedge clk);
    chk("t_busy", busy, 0);
    chk("t_err", load_error, 1);
    chk("t_cpu", cpu_reset, 1);
    chk("t_wn", wn, 1);
    chk("t_wa0", wa[0], 0);
    chk("t_wd0", wd[0], 8'h7E);

    // Byte arriving exactly at the timeout limit is processed
    wn = 0; ldn = 0;
    pulse(8'hA5);
    pulse(8'h01);
    repeat (TO - 1) @(negedge clk);
    pulse(8'h55);
    chk("tb_we", mem_we, 1);
    chk("tb_d", mem_wdata, 8'h55);
    chk("tb_busy", busy, 1);
    chk("tb_err", load_error, 0);
    pulse(8'h55);
    chk("tb_done", load_done, 1);
    chk("tb_cpu", cpu_reset, 0);

    // Reload with SYNC_BYTE as payload
    gap();
    wn = 0; ldn = 0;
    pulse(8'hA5);
    chk("r_cpu_re", cpu_reset, 1);
    gap(); pulse(8'h02);
    gap(); pulse(8'hA5);
    chk("r_we0", mem_we, 1);
    chk("r_a0", mem_addr, 0);
    chk("r_d0", mem_wdata, 8'hA5);
    gap(); pulse(8'h01);
    chk("r_a1", mem_addr, 1);
    gap(); pulse(8'hA6);
    chk("r_done", load_done, 1);
    chk("r_cpu", cpu_reset, 0);
    gap();
    chk("r_wn", wn, 2);
    chk("r_wd1", wd[1], 8'h01);

    // Reset mid-frame, then a fresh frame
    pulse(8'hA5);
    pulse(8'h04);
    pulse(8'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("m_we", mem_we, 0);
    chk("m_addr", mem_addr, 0);
    chk("m_wdata", mem_wdata, 0);
    chk("m_cpu", cpu_reset, 1);
    chk("m_busy", busy, 0);
    chk("m_err", load_error, 0);
    rst = 1'b0;
    gap();
    wn = 0; ldn = 0;
    pulse(8'hA5);
    pulse(8'h02);
    pulse(8'hC3);
    chk("m2_a0", mem_addr, 0);
    chk("m2_d0", mem_wdata, 8'hC3);
    pulse(8'h3C);
    chk("m2_a1", mem_addr, 1);
    pulse(8'hFF);
    chk("m2_done", load_done, 1);
    chk("m2_cpu", cpu_reset, 0);
    gap();
    chk("m2_wn", wn, 2);
    chk("m2_ldn", ldn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
